// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: small write-only program memory, a PC, and an IR
// presented to the execute stage through a valid/ready handshake.
module inst_fetch_unit #(
  parameter int         PROG_DEPTH = 16,
  parameter int         ADDR_W     = $clog2(PROG_DEPTH),
  parameter logic [4:0] HALT_OP    = 5'b11111
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_wdata,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              ir_ready,
  output logic              ir_valid,
  output logic [31:0]       ir,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       inst_count
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [31:0]       mem [PROG_DEPTH];
  logic [31:0]       fetch_word;
  logic [ADDR_W-1:0] pc_d;
  logic              valid_d, halted_d, load_ir, handshake;
  logic [15:0]       count_d;

  // NOTE: program storage has no reset; the loader defines its contents, and
  // leaving reset off lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_wdata;
  end

  assign fetch_word = mem[pc];
  assign handshake  = (state_q == S_VALID) && ir_valid && ir_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    state_d  = state_q;
    pc_d     = pc;
    valid_d  = ir_valid;
    halted_d = halted;
    count_d  = inst_count;
    load_ir  = 1'b0;

    if (handshake && inst_count != 16'hFFFF) count_d = inst_count + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (redirect_en)  pc_d    = redirect_pc;
        else if (start)   state_d = S_FETCH;
      end
      S_FETCH: begin
        load_ir = 1'b1;
        if (fetch_word[31:27] == HALT_OP) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_VALID;
          valid_d = 1'b1;
        end
      end
      S_VALID: begin
        if (handshake) begin
          valid_d = 1'b0;
          pc_d    = pc + ADDR_W'(1);
          state_d = S_FETCH;
        end
      end
      S_HALT: ;
      default: state_d = S_IDLE;
    endcase

    // A redirect wins over the normal flow and drops any read in flight; a
    // handshake in the same cycle has already been counted above.
    if (redirect_en && state_q != S_IDLE) begin
      pc_d     = redirect_pc;
      valid_d  = 1'b0;
      halted_d = 1'b0;
      load_ir  = 1'b0;
      state_d  = S_FETCH;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      ir_valid   <= 1'b0;
      halted     <= 1'b0;
      inst_count <= '0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      ir_valid   <= valid_d;
      halted     <= halted_d;
      inst_count <= count_d;
      if (load_ir) ir <= fetch_word;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus random
// traffic, every cycle compared against a behavioural fetch model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        sys_rst, start, prog_we, redirect_en, ir_ready;
  logic [3:0]  prog_addr, redirect_pc;
  logic [31:0] prog_wdata;
  logic        ir_valid, halted;
  logic [31:0] ir;
  logic [3:0]  pc;
  logic [15:0] inst_count;

  int checks = 0;
  int errors = 0;

  inst_fetch_unit dut (
    .clk(clk), .sys_rst(sys_rst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wdata(prog_wdata), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .ir_ready(ir_ready), .ir_valid(ir_valid),
    .ir(ir), .pc(pc), .halted(halted), .inst_count(inst_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: a running flag, a pending-read flag and the visible results.
  logic [31:0] m_mem [16];
  bit          m_run, m_reading, m_valid, m_halted;
  int          m_pc;
  logic [31:0] m_ir;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit hs;
    if (sys_rst) begin
      m_run = 0; m_reading = 0; m_valid = 0; m_halted = 0;
      m_pc = 0; m_ir = '0; m_cnt = 0;
    end else begin
      hs = m_valid && ir_ready;
      if (hs && m_cnt < 65535) m_cnt++;
      if (!m_run) begin
        if (redirect_en) m_pc = int'(redirect_pc);
        else if (start) begin m_run = 1; m_reading = 1; end
      end else if (redirect_en) begin
        m_pc = int'(redirect_pc); m_valid = 0; m_halted = 0; m_reading = 1;
      end else if (m_reading) begin
        m_ir = m_mem[m_pc];
        m_reading = 0;
        if (m_ir[31:27] == 5'h1F) m_halted = 1;
        else m_valid = 1;
      end else if (hs) begin
        m_valid = 0; m_pc = (m_pc + 1) % 16; m_reading = 1;
      end
    end
    if (prog_we) m_mem[prog_addr] = prog_wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("ir_valid", 32'(ir_valid), 32'(m_valid));
    check("halted", 32'(halted), 32'(m_halted));
    check("pc", 32'(pc), 32'(m_pc));
    check("inst_count", 32'(inst_count), 32'(m_cnt));
    check("ir", ir, m_ir);
  endtask

  task automatic clear_inputs();
    sys_rst = 0; start = 0; prog_we = 0; prog_addr = '0; prog_wdata = '0;
    redirect_en = 0; redirect_pc = '0; ir_ready = 0;
  endtask

  task automatic write_word(input int addr, input logic [31:0] data);
    prog_we = 1; prog_addr = 4'(addr); prog_wdata = data;
    tick();
    prog_we = 0;
  endtask

  function automatic logic [31:0] rand_word(input bit allow_halt);
    logic [31:0] w = $urandom;
    if (!allow_halt && w[31:27] == 5'h1F) w[31] = 1'b0;
    return w;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    bit       seen15, wrapped;
    int       saved_cnt;
    clear_inputs();
    sys_rst = 1;
    @(negedge clk);
    tick(); tick();
    sys_rst = 0;
    check("rst_valid", 32'(ir_valid), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_count", 32'(inst_count), 32'd0);
    check("rst_ir", ir, 32'd0);

    // Known contents everywhere, then the three-instruction program.
    for (int i = 0; i < 16; i++) write_word(i, rand_word(0));
    write_word(0, 32'h1100_4004);
    write_word(1, 32'h0900_0037);
    write_word(2, 32'hF800_0000);

    start = 1; ir_ready = 1;
    tick();
    start = 0;
    tick();
    check("first_valid", 32'(ir_valid), 32'd1);
    check("first_ir", ir, 32'h1100_4004);
    tick(); tick();
    check("second_ir", ir, 32'h0900_0037);
    tick(); tick();
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_count", 32'(inst_count), 32'd2);
    check("halt_pc", 32'(pc), 32'd2);

    // start is ignored in HALT; only a redirect leaves it.
    start = 1; tick(); start = 0;
    check("halt_start_ignored", 32'(halted), 32'd1);
    ir_ready = 0; redirect_en = 1; redirect_pc = 4'd0;
    tick();
    redirect_en = 0;
    check("halt_exit", 32'(halted), 32'd0);
    tick();
    check("redir_valid", 32'(ir_valid), 32'd1);
    check("redir_ir", ir, 32'h1100_4004);

    // Back-pressure: nothing moves while ir_ready is low.
    repeat (5) begin
      tick();
      check("hold_ir", ir, 32'h1100_4004);
      check("hold_pc", 32'(pc), 32'd0);
      check("hold_count", 32'(inst_count), 32'd2);
    end

    // Fill memory without HALTs and stream until the PC wraps.
    for (int i = 0; i < 16; i++) write_word(i, rand_word(0));
    ir_ready = 1; seen15 = 0; wrapped = 0;
    for (int n = 0; n < 80 && !wrapped; n++) begin
      tick();
      if (ir_valid && pc == 4'd15) seen15 = 1;
      else if (seen15 && ir_valid && pc == 4'd0) begin
        wrapped = 1;
        check("wrap_ir", ir, m_mem[0]);
      end
    end
    check("wrap_seen", 32'(wrapped), 32'd1);

    // Redirect coinciding with a handshake at pc=3.
    ir_ready = 0; redirect_en = 1; redirect_pc = 4'd3;
    tick();
    redirect_en = 0;
    tick();
    check("at3_valid", 32'(ir_valid), 32'd1);
    check("at3_pc", 32'(pc), 32'd3);
    saved_cnt = m_cnt;
    ir_ready = 1; redirect_en = 1; redirect_pc = 4'd9;
    tick();
    redirect_en = 0; ir_ready = 0;
    check("redir_hs_count", 32'(inst_count), 32'(saved_cnt + 1));
    check("redir_hs_pc", 32'(pc), 32'd9);
    tick();
    check("redir_hs_ir", ir, m_mem[9]);
    check("redir_hs_valid", 32'(ir_valid), 32'd1);

    // Random traffic, including HALT words and writes to the word being read.
    for (int n = 0; n < 300; n++) begin
      start       = ($urandom_range(0, 9) == 0);
      redirect_en = ($urandom_range(0, 11) == 0);
      redirect_pc = 4'($urandom);
      ir_ready    = ($urandom_range(0, 2) != 0);
      prog_we     = ($urandom_range(0, 5) == 0);
      prog_addr   = ($urandom_range(0, 1) == 0) ? pc : 4'($urandom);
      prog_wdata  = rand_word($urandom_range(0, 3) == 0);
      tick();
    end

    // Reset in the middle of a pending handshake.
    clear_inputs();
    for (int i = 0; i < 16; i++) write_word(i, rand_word(0));
    redirect_en = 1; redirect_pc = 4'd5;
    tick();
    redirect_en = 0;
    tick();
    tick();
    check("pre_rst_valid", 32'(ir_valid), 32'd1);
    sys_rst = 1; ir_ready = 1;
    tick();
    sys_rst = 0; ir_ready = 0;
    check("mid_rst_valid", 32'(ir_valid), 32'd0);
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_count", 32'(inst_count), 32'd0);
    tick(); tick();
    check("idle_after_rst", 32'(ir_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
